// File: rtl/gf25519_pkg.sv
// gf25519_pkg: field constants, FSM states and capture-reduce helper for GF(2^255-19)
package gf25519_pkg;
  localparam int WIDTH = 255;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] P = {WIDTH{1'b1}} - WIDTH'(18);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic logic [WIDTH-1:0] red1(input logic [WIDTH-1:0] x);
    return (x >= P) ? x - P : x;
  endfunction
endpackage

// File: rtl/gf_dbl_add_step.sv
// gf_dbl_add_step: one MSB-first interleaved step, u = (2*acc + bit*a) mod P
module gf_dbl_add_step
  import gf25519_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] u_o
);
  logic [WIDTH:0] t2, t, s, u;
  always_comb begin
    t2 = {acc_i, 1'b0};
    t = (t2 >= {1'b0, P}) ? t2 - {1'b0, P} : t2;
    s = t + {1'b0, a_i};
    u = (s >= {1'b0, P}) ? s - {1'b0, P} : s;
    u_o = bit_i ? u[WIDTH-1:0] : t[WIDTH-1:0];
  end
endmodule

// File: rtl/gf_mul_serial.sv
// gf_mul_serial: bit-serial modular multiplier, result = a*b mod P after WIDTH CALC cycles
module gf_mul_serial
  import gf25519_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, res_q, res_d, u;
  logic [CW-1:0] cnt_q, cnt_d;
  gf_dbl_add_step u_step (.acc_i(acc_q), .a_i(a_q), .bit_i(b_q[cnt_q]), .u_o(u));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = red1(a);
        b_d = red1(b);
        acc_d = '0;
        cnt_d = CW'(WIDTH - 1);
        state_d = CALC;
      end
      CALC: begin
        acc_d = u;
        cnt_d = cnt_q - 1'b1;
        res_d = (cnt_q == '0) ? u : res_q;
        state_d = (cnt_q == '0) ? DONE : CALC;
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  assign result = res_q;
  assign valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_gf_mul_serial.sv
// tb_gf_mul_serial: directed and random checks of gf_mul_serial against a wide-arithmetic model
module tb_gf_mul_serial;
  import gf25519_pkg::*;
  localparam int W = WIDTH;
  logic clk = 1'b0;
  logic rst, start, valid, busy;
  logic [W-1:0] a, b, result, r, hold;
  int lat, n_chk = 0, n_pass = 0;

  gf_mul_serial dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                     .result(result), .valid(valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] pr;
    pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(pr % {{W{1'b0}}, P});
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    case ($urandom_range(3))
      0: return P - W'($urandom_range(40));
      1: return P + W'($urandom_range(17));
      default: return t[W-1:0];
    endcase
  endfunction

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit scr,
                       output logic [W-1:0] res, output int l);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    l = 0;
    while (l < 400) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (valid) break;
      if (scr) begin
        a = rnd();
        b = rnd();
      end
    end
    res = result;
    check("latency", W'(l), W'(256));
  endtask

  task automatic drop_start(input logic [W-1:0] last);
    start = 1'b0;
    @(negedge clk);
    check("valid_drop", W'(valid), W'(0));
    check("busy_drop", W'(busy), W'(0));
    check("result_keep", result, last);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", W'(valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_result", result, '0);
    rst = 1'b0;

    do_op(W'(33), W'(33), 1'b0, r, lat);
    check("33x33", r, W'(1089));
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", W'(valid), W'(1));
      check("hold_result", result, W'(1089));
    end
    drop_start(r);

    do_op(P - W'(2), P - W'(1), 1'b0, r, lat);
    check("pm2xpm1", r, W'(2));
    drop_start(r);
    hold = '0;
    hold[254] = 1'b1;
    do_op(hold, W'(2), 1'b0, r, lat);
    check("2^254x2", r, W'(19));
    drop_start(r);

    do_op(P + W'(1), W'(5), 1'b0, r, lat);
    check("pp1x5", r, W'(5));
    drop_start(r);
    do_op('0, '1, 1'b0, r, lat);
    check("0xmax", r, '0);
    drop_start(r);

    do_op(W'(7), W'(9), 1'b1, r, lat);
    check("scramble", r, W'(63));
    drop_start(r);

    @(negedge clk);
    a = W'(11);
    b = W'(13);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", W'(valid), W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_result", result, '0);
    repeat (300) @(negedge clk);
    check("abort_novalid", W'(valid), W'(0));
    do_op(W'(3), P - W'(1), 1'b0, r, lat);
    check("3xpm1", r, P - W'(3));
    drop_start(r);

    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] x, y;
      x = rnd();
      y = rnd();
      do_op(x, y, 1'b0, r, lat);
      check("rand", r, ref_mul(x, y));
      check("rand_lt_p", W'(r < P), W'(1));
      start = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
